// File: rtl/bus_timer_pkg.sv
// Shared definitions for bus_timer: register offsets, CTRL bit layout and FSM states.
package bus_timer_pkg;

  localparam logic [1:0] TMR_CTRL  = 2'd0;
  localparam logic [1:0] TMR_LOAD  = 2'd1;
  localparam logic [1:0] TMR_COUNT = 2'd2;
  localparam logic [1:0] TMR_STAT  = 2'd3;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_AUTO      = 1;
  localparam int unsigned CTRL_IE        = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  localparam int unsigned STAT_EXP = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/bus_timer_presc.sv
// Prescale counter: emits a one-cycle tick every presc+1 clocks while run is high.
module bus_timer_presc #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;

  // >= keeps the period bounded if presc is lowered below the current count
  assign tick = run & (cnt_q >= presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Bus-attached programmable down-counter with one-shot/auto-reload modes and level irq.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r,
  input  logic        w,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq
);

  tmr_state_e         state_q, state_d;
  logic               en_q, en_d;
  logic               auto_q, auto_d;
  logic               ie_q, ie_d;
  logic               exp_q, exp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q;

  logic        accept, wr_acc, rd_acc;
  logic        ctrl_wr, load_wr, stat_wr;
  logic        run, tick, presc_clr, exp_set;
  logic [31:0] ctrl_word;
  logic        unused_wdata;

  // ready doubles as the busy flag, so a held strobe is re-accepted every other cycle
  assign accept  = (r | w) & ~ready_q;
  assign wr_acc  = accept & w;
  assign rd_acc  = accept & ~w;
  assign ctrl_wr = wr_acc & (addr == TMR_CTRL);
  assign load_wr = wr_acc & (addr == TMR_LOAD);
  assign stat_wr = wr_acc & (addr == TMR_STAT);
  assign run     = (state_q == ST_RUN);

  assign unused_wdata = ^wdata;

  bus_timer_presc #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .run  (run),
    .presc(presc_q),
    .tick (tick)
  );

  always_comb begin
    ctrl_word                                = '0;
    ctrl_word[CTRL_EN]                       = en_q;
    ctrl_word[CTRL_AUTO]                     = auto_q;
    ctrl_word[CTRL_IE]                       = ie_q;
    ctrl_word[CTRL_PRESC_LSB +: PRESC_W]     = presc_q;
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    auto_d    = auto_q;
    ie_d      = ie_q;
    presc_d   = presc_q;
    load_d    = load_q;
    count_d   = count_q;
    exp_d     = exp_q;
    presc_clr = 1'b0;
    exp_set   = 1'b0;

    if (ctrl_wr) begin
      en_d    = wdata[CTRL_EN];
      auto_d  = wdata[CTRL_AUTO];
      ie_d    = wdata[CTRL_IE];
      presc_d = wdata[CTRL_PRESC_LSB +: PRESC_W];
    end
    if (load_wr) begin
      load_d = wdata[CNT_W-1:0];
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctrl_wr) begin
          if (wdata[CTRL_EN]) begin
            count_d   = load_q;
            state_d   = ST_RUN;
            presc_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (ctrl_wr && !wdata[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            exp_set = 1'b1;
            if (auto_q) begin
              count_d = load_q;
            end else begin
              state_d = ST_DONE;
              en_d    = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A set in the same cycle as a W1C clear wins
    if (exp_set) begin
      exp_d = 1'b1;
    end else if (stat_wr && wdata[STAT_EXP]) begin
      exp_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      unique case (addr)
        TMR_CTRL:  rdata_d = ctrl_word;
        TMR_LOAD:  rdata_d = 32'(load_q);
        TMR_COUNT: rdata_d = 32'(count_q);
        TMR_STAT:  rdata_d = {31'b0, exp_q};
        default:   rdata_d = rdata_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      presc_q <= '0;
      load_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      presc_q <= presc_d;
      load_q  <= load_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      ready_q <= accept;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign irq   = exp_q & ie_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer with hand-computed expectations.
module tb_bus_timer;

  logic        clk;
  logic        rst;
  logic        r;
  logic        w;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  int n_checks;
  int n_errors;

  logic [31:0] rd;

  bus_timer #(
    .CNT_W  (32),
    .PRESC_W(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .r    (r),
    .w    (w),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives at the falling edge, accepts on the next rising edge, returns 1ns after
  // the edge where ready drops so back-to-back calls never collide with ready.
  task automatic bus_xfer(input logic do_r, input logic do_w, input logic [1:0] a,
                          input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    r     = do_r;
    w     = do_w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    r = 1'b0;
    w = 1'b0;
    check_eq("ready_pulse", {31'b0, ready}, 32'd1);
    q = rdata;
    @(posedge clk);
    #1;
    check_eq("ready_drop", {31'b0, ready}, 32'd0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] unused_q;
    bus_xfer(1'b0, 1'b1, a, d, unused_q);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] q);
    bus_xfer(1'b1, 1'b0, a, 32'h0, q);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    r        = 1'b0;
    w        = 1'b0;
    addr     = 2'd0;
    wdata    = 32'h0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_ready", {31'b0, ready}, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), rd);
      check_eq("rst_reg", rd, 32'h0);
    end

    // One-shot: LOAD=5, EN|IE -> EXP 6 clocks after the CTRL accept edge
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h5);
    repeat (4) @(posedge clk);
    #1;
    check_eq("os_irq_early", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("os_irq_set", {31'b0, irq}, 32'h1);
    bus_read(2'd0, rd);
    check_eq("os_ctrl", rd, 32'h4);
    bus_read(2'd2, rd);
    check_eq("os_count", rd, 32'h0);
    bus_read(2'd3, rd);
    check_eq("os_stat", rd, 32'h1);
    bus_read(2'd2, rd);
    check_eq("os_count_frozen", rd, 32'h0);
    bus_write(2'd3, 32'h1);
    check_eq("os_irq_clr", {31'b0, irq}, 32'h0);

    // Auto-reload, PRESC=3, LOAD=3 -> EXP every 16 clocks
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h0307);
    repeat (14) @(posedge clk);
    #1;
    check_eq("ar_irq_e15", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("ar_irq_e16", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check_eq("ar_clr1", {31'b0, irq}, 32'h0);
    repeat (13) @(posedge clk);
    #1;
    check_eq("ar_irq_e31", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("ar_irq_e32", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check_eq("ar_clr2", {31'b0, irq}, 32'h0);
    repeat (13) @(posedge clk);
    #1;
    // Clear accepted on the same edge EXP sets
    bus_write(2'd3, 32'h1);
    check_eq("ar_set_wins", {31'b0, irq}, 32'h1);

    // Handshake: held read of COUNT with PRESC=0 counting down from 100
    bus_write(2'd0, 32'h0);
    bus_write(2'd3, 32'h1);
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'h1);
    @(negedge clk);
    r    = 1'b1;
    addr = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("hs_ready", {31'b0, ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check_eq("hs_rdata", rdata, 32'd99 - 32'(2 * (i / 2)));
    end
    r = 1'b0;
    bus_xfer(1'b1, 1'b1, 2'd2, 32'h0, rd);
    check_eq("rw_rdata_kept", rd, 32'd95);
    bus_read(2'd2, rd);
    check_eq("rw_count_ignored", rd, 32'd91);

    // Reconfigure while running
    bus_write(2'd1, 32'd7);
    bus_read(2'd2, rd);
    check_eq("rc_no_reload", rd, 32'd87);
    bus_write(2'd0, 32'h0);
    bus_read(2'd2, rd);
    check_eq("rc_frozen", rd, 32'd85);
    bus_write(2'd0, 32'hFF01);
    bus_read(2'd2, rd);
    check_eq("rc_reenable", rd, 32'd7);
    check_eq("rc_irq", {31'b0, irq}, 32'h0);

    // Reset mid-count and mid-access with EXP set
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h7);
    bus_write(2'd1, 32'd40);
    @(negedge clk);
    r    = 1'b1;
    addr = 2'd2;
    @(posedge clk);
    #1;
    r = 1'b0;
    check_eq("mr_ready", {31'b0, ready}, 32'd1);
    check_eq("mr_count40", rdata, 32'd40);
    check_eq("mr_irq_pre", {31'b0, irq}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mr_ready_drop", {31'b0, ready}, 32'd0);
    check_eq("mr_rdata", rdata, 32'd0);
    check_eq("mr_irq", {31'b0, irq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), rd);
      check_eq("mr_reg", rd, 32'h0);
    end
    bus_write(2'd1, 32'd9);
    bus_read(2'd1, rd);
    check_eq("mr_load_rb", rd, 32'd9);
    bus_read(2'd2, rd);
    check_eq("mr_count_idle", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
